// File: rtl/mdu_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: issue, operands,
// read-back data and status.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic             Sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output op_valid, op, Sign, in1, in2,
    input  out, busy, stall, done
  );

  modport slave (
    input  op_valid, op, Sign, in1, in2,
    output out, busy, stall, done
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative MULT/DIV sequencer with HI/LO registers.
// Operands are reduced to magnitudes at accept, and sign correction is applied in FIX.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MFHI = 3'b011;
  localparam logic [2:0] OP_MFLO = 3'b100;
  localparam logic [2:0] OP_MTHI = 3'b101;
  localparam logic [2:0] OP_MTLO = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic               is_div_q, neg_q, rem_neg_q, div0_q;

  logic               accept, is_md, load, step, finish;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_r;
  logic [WIDTH-1:0]   div_diff, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] step_p, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign bus.stall = busy_q & bus.op_valid & (bus.op != 3'b000) & (bus.op != 3'b111);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = (bus.op == OP_MFHI) ? hi_q :
                     (bus.op == OP_MFLO) ? lo_q : '0;

  assign accept = bus.op_valid & ~bus.stall;
  assign is_md  = (bus.op == OP_MULT) | (bus.op == OP_DIV);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_md) state_d = CALC;
      CALC:    if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    unique case (state_q)
      IDLE:    load   = accept & is_md;
      CALC:    step   = 1'b1;
      FIX:     finish = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mag1 = (bus.Sign & bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
    mag2 = (bus.Sign & bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;

    // Multiply: add multiplicand on LSB, shift right. Divide: shift left, trial-subtract.
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
    div_r    = p_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_r >= {1'b0, d_q};
    div_diff = div_r[WIDTH-1:0] - d_q;
    div_rem  = div_ge ? div_diff : div_r[WIDTH-1:0];
    step_p   = is_div_q ? {div_rem, p_q[WIDTH-2:0], div_ge}
                        : {mul_sum, p_q[WIDTH-1:1]};

    prod_fix = neg_q ? -p_q : p_q;
    if (is_div_q) begin
      res_lo = div0_q ? '1 : (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
      res_hi = rem_neg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: the datapath is reset too, so an aborted operation leaves no residue in HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      p_q       <= '0;
      d_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= finish;
      if (load) begin
        cnt_q     <= '0;
        is_div_q  <= (bus.op == OP_DIV);
        p_q       <= {{WIDTH{1'b0}}, (bus.op == OP_DIV) ? mag1 : mag2};
        d_q       <= (bus.op == OP_DIV) ? mag2 : mag1;
        neg_q     <= bus.Sign & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
        rem_neg_q <= bus.Sign & bus.in1[WIDTH-1];
        div0_q    <= (bus.in2 == '0);
      end else if (step) begin
        p_q   <= step_p;
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (accept && bus.op == OP_MTHI) begin
        hi_q <= bus.in1;
      end else if (accept && bus.op == OP_MTLO) begin
        lo_q <= bus.in1;
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random MULT/DIV/MTxx
// traffic checked against an arithmetic HI/LO model.
module tb_mdu_ctrl;
  localparam int W = 32;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, DIV = 3'd2, MFHI = 3'd3,
                         MFLO = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic clk = 1'b0;
  logic reset;
  mdu_if #(.WIDTH(W)) bus();

  mdu_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r, p;
    la = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    lb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (op == MULT) begin
      p = la * lb;
      return 64'(p);
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_bus();
    bus.op_valid = 1'b0;
    bus.op       = NOP;
    bus.Sign     = 1'($urandom_range(0, 1));
    bus.in1      = $urandom;
    bus.in2      = $urandom;
  endtask

  task automatic read_hilo(input string tag);
    bus.op_valid = 1'b1;
    bus.op       = MFHI;
    #1 check({tag, "/hi"}, 64'(bus.out), 64'(m_hi));
    bus.op       = MFLO;
    #1 check({tag, "/lo"}, 64'(bus.out), 64'(m_lo));
    idle_bus();
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] data, input string tag);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.in1      = data;
    @(posedge clk); #1;
    idle_bus();
    check({tag, "/busy"}, 64'(bus.busy), 64'(0));
    check({tag, "/done"}, 64'(bus.done), 64'(0));
    if (op == MTHI) m_hi = data;
    else            m_lo = data;
    read_hilo(tag);
  endtask

  // Issues MULT/DIV, counts busy cycles, verifies the done pulse and the new HI/LO.
  task automatic run_md(input logic [2:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input string tag, input logic hold_mf);
    logic [63:0] exp;
    int cycles, bad_done, bad_stall;
    exp          = ref_md(op, sgn, a, b);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.Sign     = sgn;
    bus.in1      = a;
    bus.in2      = b;
    #1 check({tag, "/issue_stall"}, 64'(bus.stall), 64'(0));
    @(posedge clk); #1;
    idle_bus();
    if (hold_mf) begin
      bus.op_valid = 1'b1;
      bus.op       = MFLO;
    end
    #1;
    cycles = 0; bad_done = 0; bad_stall = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (bus.done !== 1'b0) bad_done++;
      if (hold_mf && bus.stall !== 1'b1) bad_stall++;
      @(posedge clk); #1;
    end
    check({tag, "/busy_cycles"}, 64'(cycles), 64'(33));
    check({tag, "/done_early"}, 64'(bad_done), 64'(0));
    check({tag, "/done"}, 64'(bus.done), 64'(1));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    if (hold_mf) begin
      check({tag, "/held_stall"}, 64'(bad_stall), 64'(0));
      check({tag, "/release_stall"}, 64'(bus.stall), 64'(0));
      check({tag, "/held_out"}, 64'(bus.out), 64'(m_lo));
    end
    read_hilo(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", 64'(bus.busy), 64'(0));
    check("rst/done", 64'(bus.done), 64'(0));
    read_hilo("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    run_md(MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, "smul_neg", 1'b0);
    @(posedge clk); #1;
    check("smul_neg/done_pulse", 64'(bus.done), 64'(0));
    run_md(MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max", 1'b0);
    run_md(MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "smul_m1", 1'b0);
    run_md(DIV,  1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7", 1'b0);
    run_md(DIV,  1'b0, 32'd100, 32'd7, "udiv_100", 1'b0);
    run_md(DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf", 1'b0);
    run_md(DIV,  1'b1, 32'h1234_5678, 32'd0, "sdiv_zero", 1'b0);
    run_md(DIV,  1'b0, 32'h1234_5678, 32'd0, "udiv_zero", 1'b0);
    run_md(MULT, 1'b0, $urandom, $urandom, "mul_hold", 1'b1);
    mt(MTHI, 32'hA5A5_A5A5, "mthi");
    mt(MTLO, $urandom, "mtlo");

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0:       mt(MTHI, $urandom, $sformatf("rnd%0d_mthi", i));
        1:       mt(MTLO, $urandom, $sformatf("rnd%0d_mtlo", i));
        2, 3:    run_md(MULT, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd(),
                        $sformatf("rnd%0d_mul", i), 1'($urandom_range(0, 1)));
        default: run_md(DIV, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd(),
                        $sformatf("rnd%0d_div", i), 1'($urandom_range(0, 1)));
      endcase
    end
    @(posedge clk); #1;
    check("rnd/done_pulse", 64'(bus.done), 64'(0));

    mt(MTHI, 32'hDEAD_BEEF, "pre_abort_hi");
    mt(MTLO, 32'h0BAD_F00D, "pre_abort_lo");
    bus.op_valid = 1'b1;
    bus.op       = DIV;
    bus.Sign     = 1'b1;
    bus.in1      = 32'h7654_3210;
    bus.in2      = 32'd3;
    @(posedge clk); #1;
    idle_bus();
    repeat (10) @(posedge clk);
    #2;
    check("abort/busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b0;
    #1;
    check("abort/busy", 64'(bus.busy), 64'(0));
    check("abort/done", 64'(bus.done), 64'(0));
    m_hi = '0;
    m_lo = '0;
    read_hilo("abort");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    read_hilo("post_rst");
    run_md(MULT, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, "post_rst_mul", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide sequencer with HI/LO registers. Sits in the EX stage beside the single-cycle ALU.
- Accepts MULT/DIV with signed or unsigned operands. Runs a 32-step shift-add or restoring-divide loop, then writes HI/LO.
- Raises a stall to the pipeline hazard logic while a later HI/LO user must wait.
- Also services MFHI/MFLO/MTHI/MTLO.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- op_valid  input  1  EX-stage instruction targets this unit this cycle
- op  input  3  000 NOP, 001 MULT, 010 DIV, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 NOP
- Sign  input  1  1 = signed MULT/DIV, 0 = unsigned; ignored for other ops
- in1  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data)
- in2  input  WIDTH  rt operand (multiplier / divisor)
- out  output  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0
- busy  output  1  registered; high while state != IDLE
- stall  output  1  combinational hazard request to pipeline
- done  output  1  registered one-cycle pulse: HI/LO just updated by MULT/DIV

Behaviour:
- Reset (async, active-low): state=IDLE; HI=LO=0; busy=0; done=0; iteration counter=0; internal operand/accumulator registers=0. Reset asserted mid-operation aborts it; HI/LO read 0 afterwards.
- Accept: an op is accepted at a rising edge when op_valid=1 and stall=0.
- stall = busy & op_valid & (op in {MULT, DIV, MFHI, MFLO, MTHI, MTLO}).
  - The pipeline holds the instruction until stall drops.
  - NOP/111 never stalls.
- States:
  - IDLE: accept MULT/DIV -> CALC, counter=0. For signed ops, latch |in1|, |in2| and result-sign flags.
  - CALC: one iteration per cycle; counter increments. When counter==WIDTH-1 at an edge -> FIX.
  - FIX: apply sign correction, write HI/LO, assert done next cycle -> IDLE.
- Latency: accepted at edge k; busy=1 from edge k+1 through edge k+WIDTH+1, i.e. WIDTH+1 = 33 cycles. HI/LO and done=1 visible after edge k+WIDTH+1, the first IDLE cycle. done=0 in all other cycles.
- MULT: 2*WIDTH-bit product.
  - Unsigned: plain shift-add.
  - Signed: magnitude product, negated (two's complement over 2*WIDTH) when operand signs differ.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- DIV: restoring division on magnitudes.
  - Quotient is negated if signs differ; remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - Divisor 0 (signed or unsigned): LO = all ones, HI = in1 unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: write HI/LO at the accepting edge. Single cycle, no busy, no done.
- MFHI/MFLO: out reflects the current HI/LO combinationally. Never returns stale data, because stall blocks it while busy.
- Simultaneous events: in the first IDLE cycle after FIX (done=1), a new op is accepted normally. MFHI/MFLO in that cycle sees the new values.
- Operand changes on in1/in2 during CALC/FIX have no effect; operands are latched at accept.
- Sign is sampled only at accept.

Test Plan:
- Signed MULT, in1=0xFFFFFFFD (-3), in2=5 -> busy high exactly 33 cycles; done pulse 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned MULT 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Signed MULT with the same operands -> HI=0, LO=1.
- Signed DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Unsigned DIV 100/7 -> LO=14, HI=2. Signed 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV by zero, in1=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678 (both signed and unsigned).
- MULT then MFLO held with op_valid=1 the next cycle -> stall=1 for 33 cycles; on the done cycle stall=0 and out=new LO. MTHI 0xA5A5A5A5 while idle -> HI updates in 1 cycle, busy stays 0.
- Assert reset low at iteration 10 of a DIV -> busy, done, HI, LO immediately 0; after release, MFHI returns 0 and a new MULT completes correctly.
